mux_32to1: RTL and testbench

MUX_32TO1 -- requirements
Module: mux_32to1

---
 rtl/mux_32to1_pkg.sv | 7 +
 rtl/mux_32to1_if.sv | 30 +++
 rtl/mux_32to1_mux_tree.sv | 16 +
 rtl/mux_32to1.sv | 53 +++++
 tb/tb_mux_32to1.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/mux_32to1_pkg.sv
// Shared constants for the 32:1 selector slice.
package mux_32to1_pkg;

  localparam int unsigned NUM_INPUTS = 32;
  localparam int unsigned SEL_W      = 5;

endpackage

// File: rtl/mux_32to1_if.sv
// Select/data/valid bundle between a requester (master) and the selector (slave).
interface mux_32to1_if
  import mux_32to1_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic [SEL_W-1:0]            S;
  logic [NUM_INPUTS*WIDTH-1:0] I;
  logic                        in_valid;
  logic [WIDTH-1:0]            P;
  logic                        out_valid;

  modport master (
    output S,
    output I,
    output in_valid,
    input  P,
    input  out_valid
  );

  modport slave (
    input  S,
    input  I,
    input  in_valid,
    output P,
    output out_valid
  );

endinterface

// File: rtl/mux_32to1_mux_tree.sv
// Pure combinational 32:1 word select; every select value maps to a real input.
module mux_tree
  import mux_32to1_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_INPUTS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]            word_c
);

  always_comb begin
    word_c = data[32'(sel) * WIDTH +: WIDTH];
  end

endmodule

// File: rtl/mux_32to1.sv
// 32:1 word selector with an optional one-cycle output register.
module mux_32to1
  import mux_32to1_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          REG_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  mux_32to1_if.slave  bus
);

  logic [WIDTH-1:0] sel_word_c;

  mux_tree #(
    .WIDTH (WIDTH)
  ) u_mux_tree (
    .sel    (bus.S),
    .data   (bus.I),
    .word_c (sel_word_c)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] p_q;
      logic             valid_q;

      // Data holds across idle cycles; valid tracks in_valid one cycle late.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= bus.in_valid;
          if (bus.in_valid) begin
            p_q <= sel_word_c;
          end
        end
      end

      assign bus.P         = p_q;
      assign bus.out_valid = valid_q;
    end else begin : g_comb
      // Clock and reset have no role in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign bus.P         = sel_word_c;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_mux_32to1.sv
// Bench for mux_32to1: registered and combinational builds against an array model.
module tb_mux_32to1;
  import mux_32to1_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int errors = 0;
  int checks = 0;

  mux_32to1_if #(.WIDTH(W)) bus_r ();
  mux_32to1_if #(.WIDTH(W)) bus_c ();

  mux_32to1 #(.WIDTH(W), .REG_OUT(1'b1)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_r)
  );

  mux_32to1 #(.WIDTH(W), .REG_OUT(1'b0)) u_dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  always #5 clk = ~clk;

  // Model state: the 32 words, the currently applied select/valid, expected outputs.
  logic [W-1:0]     words [NUM_INPUTS];
  logic [SEL_W-1:0] cur_s;
  logic             cur_v;
  logic [W-1:0]     exp_p;
  logic             exp_v;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_scaled();
    for (int k = 0; k < int'(NUM_INPUTS); k++) words[k] = W'(k * 10);
  endtask

  task automatic load_random();
    for (int k = 0; k < int'(NUM_INPUTS); k++) words[k] = $urandom;
  endtask

  // Drive both builds with the same select, data and valid, then settle.
  task automatic apply(input logic [SEL_W-1:0] s, input logic v);
    logic [NUM_INPUTS*W-1:0] vec;
    for (int k = 0; k < int'(NUM_INPUTS); k++) vec[k*W +: W] = words[k];
    cur_s          = s;
    cur_v          = v;
    bus_r.S        = s;
    bus_r.I        = vec;
    bus_r.in_valid = v;
    bus_c.S        = s;
    bus_c.I        = vec;
    bus_c.in_valid = v;
    #1;
  endtask

  // One rising edge: advance the expected registered output, sample 1 time unit later.
  task automatic tick();
    if (!rst_n) begin
      exp_p = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = cur_v;
      if (cur_v) exp_p = words[cur_s];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag);
    check({tag, "_p"}, bus_r.P, exp_p);
    check({tag, "_valid"}, W'(bus_r.out_valid), W'(exp_v));
  endtask

  logic [SEL_W-1:0] dir_sel [7];

  initial begin
    dir_sel = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd31};
    exp_p   = '0;
    exp_v   = 1'b0;

    // Reset held with random traffic; combinational build keeps selecting.
    load_random();
    apply(5'($urandom_range(0, 31)), 1'b1);
    rst_n = 1'b0;
    #1;
    check_reg("reset_assert");
    for (int c = 0; c < 4; c++) begin
      load_random();
      apply(5'($urandom_range(0, 31)), 1'b1);
      check("reset_comb_p", bus_c.P, words[cur_s]);
      tick();
      check_reg("reset_hold");
    end

    // Release with in_valid low: nothing loads until a valid edge.
    load_scaled();
    apply(5'd7, 1'b0);
    rst_n = 1'b1;
    tick();
    check_reg("release_idle");

    // Directed selects including single-bit and all-ones indices.
    foreach (dir_sel[n]) begin
      apply(dir_sel[n], 1'b1);
      tick();
      check_reg("directed");
      check("directed_value", bus_r.P, W'(32'(dir_sel[n]) * 10));
    end

    // Idle cycles with a moving select must not disturb the held word.
    for (int c = 0; c < 3; c++) begin
      apply(5'(c + 3), 1'b0);
      tick();
      check_reg("hold");
      check("hold_value", bus_r.P, W'(310));
    end

    // Load 160, wiggle inputs between edges, then reset asynchronously.
    apply(5'd16, 1'b1);
    tick();
    check("pre_reset_p", bus_r.P, W'(160));
    apply(5'd3, 1'b1);
    check("no_edge_p", bus_r.P, W'(160));
    rst_n = 1'b0;
    #1;
    exp_p = '0;
    exp_v = 1'b0;
    check_reg("async_reset");
    apply(5'd9, 1'b0);
    rst_n = 1'b1;
    tick();
    check_reg("no_stale");
    apply(5'd5, 1'b1);
    tick();
    check_reg("post_reset_load");

    // Combinational build: zero-latency sweep, valid passes straight through.
    for (int s = 0; s < int'(NUM_INPUTS); s++) begin
      apply(5'(s), 1'(s % 2));
      check("comb_sweep_p", bus_c.P, W'(s * 10));
      check("comb_sweep_valid", W'(bus_c.out_valid), W'(s % 2));
    end
    tick();

    // Random traffic against the one-cycle-delayed model.
    for (int c = 0; c < 1000; c++) begin
      load_random();
      apply(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0));
      check("rand_comb_p", bus_c.P, words[cur_s]);
      tick();
      check_reg("rand_reg");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
